// File: rtl/pcie_vc_switch.sv
// Transaction-layer crossbar: per-channel ingress/egress FIFOs, round-robin arbiter, watermarks, pop counters.
// Define STRICT_PRIO_EN for fixed lowest-channel-first arbitration instead of round-robin.
module pcie_vc_switch #(
  parameter int DATA_BITS = 8,
  parameter int DEST_BITS = 2,
  parameter int ADDR_BITS = 3,
  parameter int CNT_BITS  = 5,
  parameter int DEF_LOW   = 1,
  parameter int DEF_HIGH  = 6,
  localparam int NUM_CH   = 2 ** DEST_BITS,
  localparam int W        = DEST_BITS + DATA_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic [ADDR_BITS-1:0]  limit_low,
  input  logic [ADDR_BITS-1:0]  limit_high,
  input  logic [NUM_CH*W-1:0]   data_in,
  input  logic [NUM_CH-1:0]     push,
  input  logic [NUM_CH-1:0]     pop,
  output logic [NUM_CH*W-1:0]   data_out,
  output logic [NUM_CH-1:0]     valid_out,
  output logic [NUM_CH-1:0]     in_afull,
  output logic [NUM_CH-1:0]     out_aempty,
  input  logic                  req,
  input  logic [DEST_BITS-1:0]  idx,
  output logic [CNT_BITS-1:0]   counter_out,
  output logic                  cnt_valid,
  output logic [2:0]            state,
  output logic                  error
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam int OW    = ADDR_BITS + 1;
  localparam logic [OW-1:0] FULL_OCC = OW'(DEPTH);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  state_t st;

  logic [W-1:0]          in_mem  [NUM_CH][DEPTH];
  logic [W-1:0]          out_mem [NUM_CH][DEPTH];
  logic [ADDR_BITS-1:0]  in_wp  [NUM_CH];
  logic [ADDR_BITS-1:0]  in_rp  [NUM_CH];
  logic [ADDR_BITS-1:0]  out_wp [NUM_CH];
  logic [ADDR_BITS-1:0]  out_rp [NUM_CH];
  logic [OW-1:0]         in_occ  [NUM_CH];
  logic [OW-1:0]         out_occ [NUM_CH];
  logic [CNT_BITS-1:0]   cnt [NUM_CH];
  logic [ADDR_BITS-1:0]  lim_lo;
  logic [ADDR_BITS-1:0]  lim_hi;

  logic [DEST_BITS-1:0]  head_dest [NUM_CH];
  logic [NUM_CH-1:0]     in_full, in_empty, out_empty, eligible;
  logic [NUM_CH-1:0]     push_ok, pop_ok, take_in, put_out;
  logic                  arb_en, pop_en, any_busy, err_evt, xfer;
  logic [DEST_BITS-1:0]  gnt, gnt_dest;
  logic [W-1:0]          gnt_word;

  assign state = st;

  always_comb begin
    arb_en   = (st == S_IDLE) || (st == S_ACTIVE);
    pop_en   = (st != S_RESET) && (st != S_INIT);
    any_busy = 1'b0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      in_full[ch]    = (in_occ[ch] == FULL_OCC);
      in_empty[ch]   = (in_occ[ch] == '0);
      out_empty[ch]  = (out_occ[ch] == '0);
      head_dest[ch]  = in_mem[ch][in_rp[ch]][W-1 -: DEST_BITS];
      eligible[ch]   = arb_en && !in_empty[ch] &&
                       (out_occ[head_dest[ch]] < {1'b0, lim_hi});
      in_afull[ch]   = (in_occ[ch] >= {1'b0, lim_hi});
      out_aempty[ch] = (out_occ[ch] <= {1'b0, lim_lo});
      any_busy       = any_busy | !in_empty[ch] | !out_empty[ch];
    end
  end

`ifdef STRICT_PRIO_EN
  // Scan downwards so the lowest eligible channel is the last one assigned.
  always_comb begin
    xfer = 1'b0;
    gnt  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        xfer = 1'b1;
        gnt  = DEST_BITS'(i);
      end
    end
  end
`else
  logic [DEST_BITS-1:0] last_grant;
  logic [DEST_BITS-1:0] cand;

  // Offsets scanned from farthest to nearest; offset NUM_CH truncates to last_grant itself.
  always_comb begin
    xfer = 1'b0;
    gnt  = '0;
    cand = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      cand = last_grant + DEST_BITS'(i);
      if (eligible[cand]) begin
        xfer = 1'b1;
        gnt  = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      last_grant <= DEST_BITS'(NUM_CH - 1);
    else if (xfer)
      last_grant <= gnt;
  end
`endif

  always_comb begin
    gnt_word = in_mem[gnt][in_rp[gnt]];
    gnt_dest = gnt_word[W-1 -: DEST_BITS];
    err_evt  = 1'b0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      push_ok[ch] = push[ch] & ~in_full[ch];
      pop_ok[ch]  = pop_en & pop[ch] & ~out_empty[ch];
      take_in[ch] = xfer && (gnt == DEST_BITS'(ch));
      put_out[ch] = xfer && (gnt_dest == DEST_BITS'(ch));
      err_evt     = err_evt | (push[ch] & in_full[ch]) | (pop_en & pop[ch] & out_empty[ch]);
    end
  end

  // FIFO storage carries no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (push_ok[ch])
        in_mem[ch][in_wp[ch]] <= data_in[ch*W +: W];
      if (put_out[ch])
        out_mem[ch][out_wp[ch]] <= gnt_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st          <= S_RESET;
      error       <= 1'b0;
      lim_lo      <= ADDR_BITS'(DEF_LOW);
      lim_hi      <= ADDR_BITS'(DEF_HIGH);
      data_out    <= '0;
      valid_out   <= '0;
      counter_out <= '0;
      cnt_valid   <= 1'b0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        in_wp[ch]   <= '0;
        in_rp[ch]   <= '0;
        out_wp[ch]  <= '0;
        out_rp[ch]  <= '0;
        in_occ[ch]  <= '0;
        out_occ[ch] <= '0;
        cnt[ch]     <= '0;
      end
    end else begin
      case (st)
        S_RESET: st <= S_INIT;
        S_ERROR: st <= S_ERROR;
        default: begin
          if (err_evt)          st <= S_ERROR;
          else if (init)        st <= S_INIT;
          else if (st == S_INIT) st <= S_IDLE;
          else                  st <= any_busy ? S_ACTIVE : S_IDLE;
        end
      endcase

      error <= error | err_evt;

      if (st == S_INIT) begin
        lim_lo <= limit_low;
        lim_hi <= limit_high;
      end

      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (push_ok[ch]) in_wp[ch] <= in_wp[ch] + 1'b1;
        if (take_in[ch]) in_rp[ch] <= in_rp[ch] + 1'b1;
        in_occ[ch] <= in_occ[ch] + OW'(push_ok[ch]) - OW'(take_in[ch]);

        if (put_out[ch]) out_wp[ch] <= out_wp[ch] + 1'b1;
        if (pop_ok[ch]) begin
          out_rp[ch]           <= out_rp[ch] + 1'b1;
          data_out[ch*W +: W]  <= out_mem[ch][out_rp[ch]];
          cnt[ch]              <= cnt[ch] + CNT_BITS'(1);
        end
        out_occ[ch]   <= out_occ[ch] + OW'(put_out[ch]) - OW'(pop_ok[ch]);
        valid_out[ch] <= pop_ok[ch];
      end

      if (req) begin
        counter_out <= cnt[idx];
        cnt_valid   <= 1'b1;
      end else begin
        counter_out <= '0;
        cnt_valid   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pcie_vc_switch.sv
// Bench for pcie_vc_switch: directed scenarios plus random traffic against a queue-based reference model.
module tb_pcie_vc_switch;
  localparam int DSB   = 2;
  localparam int NC    = 4;
  localparam int W     = 10;
  localparam int DEPTH = 8;

  typedef logic [W-1:0] word_t;

  logic          clk = 1'b0;
  logic          reset, init, req;
  logic [2:0]    limit_low, limit_high;
  logic [NC*W-1:0] data_in;
  logic [NC-1:0] push, pop;
  logic [DSB-1:0] idx;
  logic [NC*W-1:0] data_out;
  logic [NC-1:0] valid_out, in_afull, out_aempty;
  logic [4:0]    counter_out;
  logic          cnt_valid, error;
  logic [2:0]    state;

  always #5 clk = ~clk;

  pcie_vc_switch dut (
    .clk(clk), .reset(reset), .init(init),
    .limit_low(limit_low), .limit_high(limit_high),
    .data_in(data_in), .push(push), .pop(pop),
    .data_out(data_out), .valid_out(valid_out),
    .in_afull(in_afull), .out_aempty(out_aempty),
    .req(req), .idx(idx), .counter_out(counter_out), .cnt_valid(cnt_valid),
    .state(state), .error(error)
  );

  // Reference model: FIFOs as queues, state as plain integers.
  word_t inq  [NC][$];
  word_t outq [NC][$];
  int    m_st, m_lo, m_hi, m_lg, m_cout;
  int    m_cnt [NC];
  word_t m_dout [NC];
  bit [NC-1:0] m_vout;
  bit    m_err, m_cval;

  int    n_vec = 0;
  int    n_err = 0;
  string phase = "init";

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit arb, popen, any_ne, ev;
    bit full_pre [NC];
    int g, c, ns;
    word_t h, wd;
    if (reset) begin
      for (int k = 0; k < NC; k++) begin
        inq[k].delete();
        outq[k].delete();
        m_cnt[k]  = 0;
        m_dout[k] = '0;
      end
      m_vout = '0; m_st = 0; m_err = 0; m_lo = 1; m_hi = 6; m_lg = NC - 1;
      m_cout = 0; m_cval = 0;
      return;
    end
    arb    = (m_st == 2) || (m_st == 3);
    popen  = (m_st != 0) && (m_st != 1);
    any_ne = 0;
    ev     = 0;
    g      = -1;
    for (int k = 0; k < NC; k++) begin
      any_ne      = any_ne || (inq[k].size() > 0) || (outq[k].size() > 0);
      full_pre[k] = (inq[k].size() == DEPTH);
    end
    for (int k = 0; k < NC; k++) begin
`ifdef STRICT_PRIO_EN
      c = k;
`else
      c = (m_lg + 1 + k) % NC;
`endif
      if (g < 0 && arb && inq[c].size() > 0) begin
        h = inq[c][0];
        if (outq[h[W-1 -: DSB]].size() < m_hi) g = c;
      end
    end
    if (req) begin
      m_cout = m_cnt[idx];
      m_cval = 1;
    end else begin
      m_cout = 0;
      m_cval = 0;
    end
    for (int k = 0; k < NC; k++) begin
      m_vout[k] = 0;
      if (pop[k] && popen) begin
        if (outq[k].size() > 0) begin
          m_dout[k] = outq[k].pop_front();
          m_vout[k] = 1;
          m_cnt[k]  = (m_cnt[k] + 1) % 32;
        end else begin
          ev = 1;
        end
      end
    end
    if (g >= 0) begin
      wd = inq[g].pop_front();
      outq[wd[W-1 -: DSB]].push_back(wd);
      m_lg = g;
    end
    for (int k = 0; k < NC; k++) begin
      if (push[k]) begin
        if (full_pre[k]) ev = 1;
        else inq[k].push_back(data_in[k*W +: W]);
      end
    end
    if (m_st == 0)      ns = 1;
    else if (m_st == 4) ns = 4;
    else if (ev)        ns = 4;
    else if (init)      ns = 1;
    else if (m_st == 1) ns = 2;
    else                ns = any_ne ? 3 : 2;
    if (m_st == 1) begin
      m_lo = int'(limit_low);
      m_hi = int'(limit_high);
    end
    m_st  = ns;
    m_err = m_err | ev;
  endtask

  task automatic compare_all();
    logic [NC*W-1:0] edo;
    logic [NC-1:0]   eaf, eae;
    for (int k = 0; k < NC; k++) begin
      edo[k*W +: W] = m_dout[k];
      eaf[k] = (inq[k].size() >= m_hi);
      eae[k] = (outq[k].size() <= m_lo);
    end
    check("state",       64'(state),       64'(m_st));
    check("error",       64'(error),       64'(m_err));
    check("valid_out",   64'(valid_out),   64'(m_vout));
    check("data_out",    64'(data_out),    64'(edo));
    check("counter_out", 64'(counter_out), 64'(m_cout));
    check("cnt_valid",   64'(cnt_valid),   64'(m_cval));
    check("in_afull",    64'(in_afull),    64'(eaf));
    check("out_aempty",  64'(out_aempty),  64'(eae));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic quiet();
    push = '0; pop = '0; req = 1'b0; idx = '0; init = 1'b0; data_in = '0;
  endtask

  task automatic do_init(input logic [2:0] lo, input logic [2:0] hi);
    quiet();
    reset = 1'b1; cycle();
    reset = 1'b0; init = 1'b1; limit_low = lo; limit_high = hi;
    cycle(); cycle();
    init = 1'b0; cycle();
  endtask

  int npop;

  initial begin
    reset = 1'b1; limit_low = 3'd1; limit_high = 3'd6;
    quiet();

    phase = "s1_reset_init";
    cycle(); cycle();
    check("rst_state", 64'(state), 64'd0);
    check("rst_aempty", 64'(out_aempty), 64'hF);
    check("rst_afull", 64'(in_afull), 64'h0);
    reset = 1'b0; init = 1'b1;
    cycle(); check("to_init", 64'(state), 64'd1);
    cycle(); check("hold_init", 64'(state), 64'd1);
    init = 1'b0;
    cycle(); check("to_idle", 64'(state), 64'd2);

    phase = "s2_single";
    push = 4'b0001; data_in = '0; data_in[W-1:0] = 10'h1A5;
    cycle();
    quiet(); cycle();
    pop = 4'b0010; cycle();
    check("dout1", 64'(data_out[2*W-1:W]), 64'h1A5);
    check("vout1", 64'(valid_out), 64'h2);
    quiet(); req = 1'b1; idx = 2'd1; cycle();
    check("cnt1", 64'(counter_out), 64'd1);
    quiet(); cycle();

    phase = "s3_rr_fill";
    do_init(3'd1, 3'd6);
    for (int t = 0; t < 7; t++) begin
      push = 4'hF;
      for (int k = 0; k < NC; k++) data_in[k*W +: W] = {2'd3, 8'(16 * k + t)};
      cycle();
    end
    quiet();
`ifdef STRICT_PRIO_EN
    check("afull", 64'(in_afull), 64'hE);
`else
    check("afull", 64'(in_afull), 64'hC);
`endif
    check("no_err", 64'(error), 64'd0);

    phase = "s4_overflow";
    do_init(3'd1, 3'd0);
    for (int t = 0; t < 9; t++) begin
      push = 4'b0100; data_in = '0; data_in[2*W +: W] = {2'd0, 8'(t)};
      cycle();
    end
    quiet();
    check("ovf_err", 64'(error), 64'd1);
    check("ovf_state", 64'(state), 64'd4);
    reset = 1'b1; cycle();
    check("ovf_clr", 64'(error), 64'd0);
    reset = 1'b0;

    phase = "s5_underflow";
    do_init(3'd1, 3'd6);
    pop = 4'b0001; cycle();
    check("uf_vout", 64'(valid_out), 64'd0);
    check("uf_err", 64'(error), 64'd1);
    quiet(); cycle();

    phase = "s6_wrap";
    do_init(3'd1, 3'd6);
    npop = 0;
    for (int t = 0; t < 200 && npop < 33; t++) begin
      push = 4'b0001; data_in = '0; data_in[W-1:0] = {2'd2, 8'(t)};
      if (outq[2].size() > 0) begin
        pop = 4'b0100;
        npop++;
      end else begin
        pop = '0;
      end
      cycle();
    end
    check("pops", 64'(npop), 64'd33);
    quiet(); req = 1'b1; idx = 2'd2; cycle();
    check("wrap_cnt", 64'(counter_out), 64'd1);
    check("no_err", 64'(error), 64'd0);

    phase = "rand";
    for (int seg = 0; seg < 4; seg++) begin
      do_init(3'($urandom_range(0, 7)), 3'($urandom_range(1, 7)));
      for (int t = 0; t < 150; t++) begin
        logic [NC-1:0] legal;
        for (int k = 0; k < NC; k++) legal[k] = (outq[k].size() > 0);
        data_in    = 40'({$urandom(), $urandom()});
        push       = 4'($urandom());
        pop        = ($urandom_range(0, 15) == 0) ? 4'($urandom()) : (4'($urandom()) & legal);
        req        = 1'($urandom());
        idx        = 2'($urandom());
        limit_low  = 3'($urandom());
        limit_high = 3'($urandom());
        init       = ($urandom_range(0, 39) == 0);
        reset      = ($urandom_range(0, 99) == 0);
        cycle();
      end
      reset = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
